// File: rtl/unibus_pkg.sv
// Shared Unibus definitions: cycle-type codes, bus-master state encoding and
// the filler value returned for unmapped register addresses.
package unibus_pkg;

  // Unibus C1:C0 cycle-type codes
  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATIP = 2'b01;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Bus-master sequencer states; the encoding is visible through a status register
  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StReq   = 4'd1,
    StSack  = 4'd2,
    StAddr  = 4'd3,
    StMsyn  = 4'd4,
    StLatch = 4'd5,
    StRelms = 4'd6,
    StDone  = 4'd7
  } npr_state_e;

  // Cycle type for a single-word transfer; reads are always plain DATI
  function automatic logic [1:0] cycle_type(input logic is_write, input logic byte_sel);
    logic [1:0] c;
    if (!is_write) begin
      c = C_DATI;
    end else if (byte_sel) begin
      c = C_DATOB;
    end else begin
      c = C_DATO;
    end
    return c;
  endfunction

endpackage

// File: rtl/npr_dma.sv
// Unibus NPR bus master: runs one DATI/DATO/DATOB cycle per ARM request and
// raises armintrq when the cycle finishes, times out or is aborted by INIT.
module npr_dma
  import unibus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned DESKEW  = 15
) (
  input  logic        CLOCK,
  input  logic        RESET,

  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,

  input  logic        init_in_h,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        sack_out_h,
  input  logic        bbsy_in_h,
  output logic        bbsy_out_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h
);

  localparam logic [31:0] NprDmaId  = 32'h444D1001;
  localparam logic [15:0] DeskewM1  = 16'(DESKEW - 1);
  localparam logic [15:0] TimeoutM1 = 16'(TIMEOUT - 1);

  npr_state_e  r_state;
  npr_state_e  w_state_d;
  logic [15:0] r_timer;
  logic [15:0] w_timer_d;

  // Transfer description latched by a go write
  logic        r_write;
  logic        r_byte;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;

  logic        r_done;
  logic        r_timeout;

  // Registered bus drivers
  logic        r_npr;
  logic        r_sack;
  logic        r_bbsy;
  logic        r_msyn;
  logic [17:0] r_a;
  logic [1:0]  r_c;
  logic [15:0] r_d;

  logic        w_busy;
  logic        w_abort;
  logic        w_reg1_wr;
  logic        w_go;
  logic        w_ack;
  logic        w_timed_out;
  logic        w_active_d;
  logic        w_enter_addr;
  logic        w_capture;
  logic [17:0] w_addr_eff;
  logic        w_unused_bits;

  assign w_busy    = (r_state != StIdle);
  assign w_abort   = init_in_h && w_busy;
  assign w_reg1_wr = armwrite && (armwaddr == 2'd1) && !w_busy;
  assign w_go      = w_reg1_wr && armwdata[31];
  assign w_ack     = w_reg1_wr && !armwdata[31];

  // Word writes must land on an even address
  assign w_addr_eff = (r_write && !r_byte) ? {r_addr[17:1], 1'b0} : r_addr;

  // Address/data are owned by this master from ADDR until RELMS ends
  assign w_active_d   = (w_state_d == StAddr) || (w_state_d == StMsyn) ||
                        (w_state_d == StLatch) || (w_state_d == StRelms);
  assign w_enter_addr = (w_state_d == StAddr) && (r_state != StAddr);
  assign w_capture    = (r_state == StLatch) && (w_state_d == StRelms) && !r_write;

  assign w_unused_bits = ^{armwdata[28:18], C_DATIP};

  // Next-state logic for the bus cycle sequencer
  always_comb begin
    w_state_d   = r_state;
    w_timed_out = 1'b0;
    unique case (r_state)
      StIdle:  if (w_go) w_state_d = StReq;
      StReq:   if (npg_in_h) w_state_d = StSack;
      // A previous slave still holding ssyn is not an error; just wait it out
      StSack:  if (!bbsy_in_h && !ssyn_in_h) w_state_d = StAddr;
      StAddr:  if (r_timer == DeskewM1) w_state_d = StMsyn;
      StMsyn: begin
        if (ssyn_in_h) begin
          w_state_d = StLatch;
        end else if (r_timer == TimeoutM1) begin
          w_state_d   = StRelms;
          w_timed_out = 1'b1;
        end
      end
      StLatch: if (r_timer == DeskewM1) w_state_d = StRelms;
      // After a timeout nobody will ever answer, so do not wait for ssyn
      StRelms: if (!ssyn_in_h || r_timeout) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_abort) begin
      w_state_d   = StIdle;
      w_timed_out = 1'b0;
    end
  end

  // Timer restarts on every state change and only runs in the timed states
  always_comb begin
    w_timer_d = '0;
    if ((w_state_d == r_state) &&
        ((r_state == StAddr) || (r_state == StMsyn) || (r_state == StLatch))) begin
      w_timer_d = r_timer + 16'd1;
    end
  end

  // State and timer registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_timer <= '0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
    end
  end

  // Transfer parameters, status flags and read-data capture
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_write   <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (armwrite && (armwaddr == 2'd2)) begin
        r_wdata <= armwdata[15:0];
      end
      if (w_abort) begin
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end else begin
        if (w_go) begin
          r_write   <= armwdata[30];
          r_byte    <= armwdata[29];
          r_addr    <= armwdata[17:0];
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
        end else if (w_ack) begin
          r_done <= 1'b0;
        end
        if (w_timed_out) begin
          r_timeout <= 1'b1;
        end
        if (r_state == StDone) begin
          r_done <= 1'b1;
        end
        if (w_capture) begin
          r_rdata <= d_in_h;
        end
      end
    end
  end

  // Bus outputs are registered from the next state so each changes once per edge
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_npr  <= 1'b0;
      r_sack <= 1'b0;
      r_bbsy <= 1'b0;
      r_msyn <= 1'b0;
      r_a    <= '0;
      r_c    <= '0;
      r_d    <= '0;
    end else begin
      r_npr  <= (w_state_d == StReq);
      r_sack <= (w_state_d == StSack);
      r_bbsy <= w_active_d;
      r_msyn <= (w_state_d == StMsyn) || (w_state_d == StLatch);
      if (w_enter_addr) begin
        r_a <= w_addr_eff;
        r_c <= cycle_type(r_write, r_byte);
        r_d <= r_write ? r_wdata : 16'd0;
      end else if (!w_active_d) begin
        r_a <= '0;
        r_c <= '0;
        r_d <= '0;
      end
    end
  end

  // ARM register read mux
  always_comb begin
    armrdata = DEADBEEF;
    case (armraddr)
      2'd0:    armrdata = NprDmaId;
      2'd1:    armrdata = {w_busy, r_write, r_byte, r_timeout, r_done, 9'd0, r_addr};
      2'd2:    armrdata = {r_rdata, r_wdata};
      2'd3:    armrdata = {r_state, 12'd0, r_timer};
      default: armrdata = DEADBEEF;
    endcase
  end

  assign armintrq   = r_done;
  assign npr_out_h  = r_npr;
  assign sack_out_h = r_sack;
  assign bbsy_out_h = r_bbsy;
  assign msyn_out_h = r_msyn;
  assign a_out_h    = r_a;
  assign c_out_h    = r_c;
  assign d_out_h    = r_d;

endmodule

// File: tb/tb_npr_dma.sv
// Scoreboard bench for npr_dma: stimulus queues expected bus cycles and
// completion status; a slave model and a completion monitor check them.
module tb_npr_dma;

  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned DESKEW  = 15;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        armintrq;
  logic        init_in_h;
  logic        npr_out_h;
  logic        npg_in_h;
  logic        sack_out_h;
  logic        bbsy_in_h;
  logic        bbsy_out_h;
  logic        ssyn_in_h;
  logic [15:0] d_in_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        msyn_out_h;

  npr_dma #(
    .TIMEOUT(TIMEOUT),
    .DESKEW (DESKEW)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .armwrite  (armwrite),
    .armraddr  (armraddr),
    .armwaddr  (armwaddr),
    .armwdata  (armwdata),
    .armrdata  (armrdata),
    .armintrq  (armintrq),
    .init_in_h (init_in_h),
    .npr_out_h (npr_out_h),
    .npg_in_h  (npg_in_h),
    .sack_out_h(sack_out_h),
    .bbsy_in_h (bbsy_in_h),
    .bbsy_out_h(bbsy_out_h),
    .ssyn_in_h (ssyn_in_h),
    .d_in_h    (d_in_h),
    .a_out_h   (a_out_h),
    .c_out_h   (c_out_h),
    .d_out_h   (d_out_h),
    .msyn_out_h(msyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [17:0] a;
    logic [1:0]  c;
    logic [15:0] d;
    logic [15:0] data;   // value the slave returns
    logic        answer; // slave responds with ssyn
    int          hi;     // required msyn-high cycles, 0 = not checked
  } bus_t;

  typedef struct {
    logic [31:0] reg1;
    logic [31:0] reg2;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];

  int total = 0;
  int bad   = 0;
  int grant_delay = 0;
  int bbsy_hold   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic arm_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge CLOCK);
    #1;
    armwrite = 1'b1;
    armwaddr = addr;
    armwdata = data;
    @(posedge CLOCK);
    #1;
    armwrite = 1'b0;
  endtask

  task automatic start(input logic wr, input logic bt, input logic [17:0] addr,
                       input logic [15:0] wdata, input logic [17:0] exp_a,
                       input logic [1:0] exp_c, input logic [15:0] mem_data,
                       input logic answer, input int hi, input logic [31:0] exp_reg1,
                       input logic [15:0] exp_rdata);
    bus_t  b;
    done_t d;
    b.a = exp_a;
    b.c = exp_c;
    b.d = wr ? wdata : 16'd0;
    b.data = mem_data;
    b.answer = answer;
    b.hi = hi;
    d.reg1 = exp_reg1;
    d.reg2 = {exp_rdata, wdata};
    bus_q.push_back(b);
    done_q.push_back(d);
    arm_write(2'd2, {16'd0, wdata});
    arm_write(2'd1, {1'b1, wr, bt, 11'd0, addr});
    check("npr_n1", npr_out_h, 1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!armintrq && n < limit) begin
      @(negedge CLOCK);
      n++;
    end
    check("done_wait", armintrq, 1);
    repeat (3) @(negedge CLOCK);
  endtask

  // Arbiter model: grants after grant_delay, keeps another master on the bus for bbsy_hold
  initial begin : arbiter
    logic saw;
    npg_in_h  = 1'b0;
    bbsy_in_h = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (npr_out_h && !npg_in_h) begin
        for (int i = 0; i < grant_delay; i++) @(negedge CLOCK);
        check("npr_held", npr_out_h, 1);
        npg_in_h  = 1'b1;
        bbsy_in_h = (bbsy_hold != 0);
        @(negedge CLOCK);
        check("sack_m1", sack_out_h, 1);
        npg_in_h = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < bbsy_hold; i++) begin
          if (bbsy_out_h) saw = 1'b1;
          @(negedge CLOCK);
        end
        if (bbsy_hold != 0) check("bbsy_wait", saw, 0);
        bbsy_in_h = 1'b0;
      end
    end
  end

  // Slave model and bus-cycle scoreboard
  initial begin : mem_model
    bus_t cur;
    logic have;
    logic ms_prev;
    int   bb_cnt;
    int   ms_cnt;
    have = 1'b0;
    ms_prev = 1'b0;
    bb_cnt = 0;
    ms_cnt = 0;
    ssyn_in_h = 1'b0;
    d_in_h = 16'd0;
    forever begin
      @(negedge CLOCK);
      if (!bbsy_out_h) bb_cnt = 0;
      else if (!msyn_out_h && !have) bb_cnt++;
      if (msyn_out_h && !ms_prev) begin
        ms_cnt = 0;
        if (bus_q.size() == 0) begin
          check("bus_unexpected", 1, 0);
          have = 1'b0;
        end else begin
          cur = bus_q.pop_front();
          have = 1'b1;
          check("deskew", bb_cnt, DESKEW);
          check("bus_a", a_out_h, cur.a);
          check("bus_c", c_out_h, cur.c);
          check("bus_d", d_out_h, cur.d);
        end
      end
      if (msyn_out_h) begin
        ms_cnt++;
        if (have && cur.answer && ms_cnt == 3) begin
          ssyn_in_h = 1'b1;
          d_in_h = cur.data;
        end
      end else begin
        if (ms_prev && have && cur.hi != 0) check("msyn_high", ms_cnt, cur.hi);
        if (ms_prev) have = 1'b0;
        ssyn_in_h = 1'b0;
      end
      ms_prev = msyn_out_h;
    end
  end

  // Completion monitor: status, data and an idle bus on each armintrq rise
  initial begin : done_mon
    done_t e;
    logic  prev;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (armintrq && !prev) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = done_q.pop_front();
          armraddr = 2'd1;
          #1;
          check("reg1", armrdata, e.reg1);
          armraddr = 2'd2;
          #1;
          check("reg2", armrdata, e.reg2);
          check("bus_idle", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h,
                             a_out_h, c_out_h, d_out_h}, 0);
        end
      end
      prev = armintrq;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    RESET = 1'b1;
    armwrite = 1'b0;
    armraddr = 2'd0;
    armwaddr = 2'd0;
    armwdata = 32'd0;
    init_in_h = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    check("reset_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h,
                        a_out_h, c_out_h, d_out_h, armintrq}, 0);
    armraddr = 2'd0;
    #1;
    check("reg0_id", armrdata, 32'h444D1001);
    armraddr = 2'd1;
    #1;
    check("reset_reg1", armrdata, 32'h0);
    armraddr = 2'd3;
    #1;
    check("reset_reg3", armrdata, 32'h0);
    armraddr = 2'd1;

    // DATI 001000 -> 123456
    start(1'b0, 1'b0, 18'o001000, 16'h0000, 18'o001000, 2'b00, 16'o123456, 1'b1, 0,
          32'h0800_0200, 16'o123456);
    wait_done(500);

    // DATOB 001001, data 177400; rdata unchanged
    start(1'b1, 1'b1, 18'o001001, 16'o177400, 18'o001001, 2'b11, 16'h0000, 1'b1, 0,
          32'h6800_0201, 16'o123456);
    wait_done(500);

    // Word DATO on odd address: A0 forced low
    start(1'b1, 1'b0, 18'o001001, 16'o052525, 18'o001000, 2'b10, 16'h0000, 1'b1, 0,
          32'h4800_0201, 16'o123456);
    wait_done(500);

    // Nonexistent memory: msyn high exactly TIMEOUT cycles
    start(1'b0, 1'b0, 18'o760000, 16'h0000, 18'o760000, 2'b00, 16'h0000, 1'b0, TIMEOUT,
          32'h1803_E000, 16'o123456);
    wait_done(5000);

    // Arbitration: late grant, other master busy, go while busy ignored
    grant_delay = 50;
    bbsy_hold = 20;
    start(1'b0, 1'b0, 18'o002000, 16'h0000, 18'o002000, 2'b00, 16'h01FF, 1'b1, 0,
          32'h0800_0400, 16'h01FF);
    repeat (10) @(posedge CLOCK);
    arm_write(2'd1, {1'b1, 1'b1, 1'b0, 11'd0, 18'o777777});
    wait_done(500);
    grant_delay = 0;
    bbsy_hold = 0;

    // INIT during MSYN aborts the cycle
    start(1'b1, 1'b0, 18'o004000, 16'h1234, 18'o004000, 2'b10, 16'h0000, 1'b0, 0,
          32'h5800_0800, 16'h01FF);
    n = 0;
    while (!msyn_out_h && n < 200) begin
      @(negedge CLOCK);
      n++;
    end
    check("msyn_wait", msyn_out_h, 1);
    repeat (5) @(posedge CLOCK);
    #1;
    init_in_h = 1'b1;
    @(posedge CLOCK);
    #1;
    init_in_h = 1'b0;
    check("init_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h,
                       a_out_h, c_out_h, d_out_h}, 0);
    check("init_done", armintrq, 1);
    repeat (3) @(negedge CLOCK);

    // Normal transfer after the abort
    start(1'b0, 1'b0, 18'o004002, 16'h0000, 18'o004002, 2'b00, 16'h4321, 1'b1, 0,
          32'h0800_0802, 16'h4321);
    wait_done(500);

    check("bus_q_empty", bus_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
